// File: rtl/reg_file_wb.sv
// Register file terminating the write-back path: R0-R7 plus T/SP/IH/RA,
// two combinational read ports with same-cycle WB bypass and a registered debug port.
module reg_file_wb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int NUM_GPR = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] rx_addr,
  input  logic [ADDR_W-1:0] ry_addr,
  output logic [DATA_W-1:0] rx_data,
  output logic [DATA_W-1:0] ry_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              wb_err
);

  // General registers followed by T, SP, IH, RA; addresses above these are reserved.
  localparam int NUM_REGS = NUM_GPR + 4;
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(NUM_REGS);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wb_err_q, wb_err_d;
  logic [DATA_W-1:0] dbg_data_q, dbg_data_d;

  logic              wb_valid;
  logic [DATA_W-1:0] rx_stored, ry_stored;
  logic              rx_hit, ry_hit;

  assign wb_valid = (wb_addr < LIMIT);

  // Gating on wb_en first keeps an undriven wb_addr from reaching state.
  always_comb begin
    regs_d   = regs_q;
    wb_err_d = wb_err_q;
    if (wb_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wb_addr == ADDR_W'(i)) regs_d[i] = wb_data;
      end
      if (!wb_valid) wb_err_d = 1'b1;
    end
  end

  always_comb begin
    rx_stored  = '0;
    ry_stored  = '0;
    dbg_data_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rx_addr == ADDR_W'(i))  rx_stored  = regs_q[i];
      if (ry_addr == ADDR_W'(i))  ry_stored  = regs_q[i];
      if (dbg_addr == ADDR_W'(i)) dbg_data_d = regs_q[i];
    end
    // A reserved read address can only match a reserved write, so wb_valid blocks it.
    rx_hit = !rst && wb_en && wb_valid && (rx_addr == wb_addr);
    ry_hit = !rst && wb_en && wb_valid && (ry_addr == wb_addr);
  end

  assign rx_data = rx_hit ? wb_data : rx_stored;
  assign ry_data = ry_hit ? wb_data : ry_stored;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wb_err_q   <= 1'b0;
      dbg_data_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wb_err_q   <= wb_err_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  assign dbg_data = dbg_data_q;
  assign wb_err   = wb_err_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed, table-driven bench for reg_file_wb: vectors for write/read/bypass/debug,
// plus hand-written sequences for reset behaviour.
module tb_reg_file_wb;

  logic        clk;
  logic        rst;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic [3:0]  rx_addr, ry_addr, dbg_addr;
  logic [15:0] rx_data, ry_data, dbg_data;
  logic        wb_err;

  int checks;
  int failures;

  typedef struct {
    logic        en;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic [3:0]  rx;
    logic [3:0]  ry;
    logic [3:0]  dbg;
    logic [15:0] exp_rx;
    logic [15:0] exp_ry;
    logic [15:0] exp_dbg;
    logic        exp_err;
  } vec_t;

  vec_t vecs [14];

  reg_file_wb #(.DATA_W(16), .ADDR_W(4), .NUM_GPR(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .rx_addr  (rx_addr),
    .ry_addr  (ry_addr),
    .rx_data  (rx_data),
    .ry_data  (ry_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wb_err   (wb_err)
  );

  // Free-running clock; inputs change on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", name, actual, expected);
    end
  endtask

  // Drives every DUT input from a vector record.
  task automatic applyStimulus(input vec_t v);
    wb_en    = v.en;
    wb_addr  = v.waddr;
    wb_data  = v.wdata;
    rx_addr  = v.rx;
    ry_addr  = v.ry;
    dbg_addr = v.dbg;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Expected values trace the register contents cycle by cycle from all-zero.
    //            en    waddr  wdata     rx     ry     dbg    exp_rx    exp_ry    exp_dbg   err
    vecs[0]  = '{1'b1, 4'd3,  16'h1234, 4'd3,  4'd9,  4'd3,  16'h1234, 16'h0000, 16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 4'd9,  16'hBEEF, 4'd3,  4'd9,  4'd3,  16'h1234, 16'hBEEF, 16'h1234, 1'b0};
    vecs[2]  = '{1'b1, 4'd11, 16'h00FF, 4'd3,  4'd9,  4'd11, 16'h1234, 16'hBEEF, 16'h0000, 1'b0};
    vecs[3]  = '{1'b0, 4'd0,  16'h0000, 4'd11, 4'd3,  4'd11, 16'h00FF, 16'h1234, 16'h00FF, 1'b0};
    vecs[4]  = '{1'b1, 4'd5,  16'h0001, 4'd0,  4'd8,  4'd5,  16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[5]  = '{1'b1, 4'd5,  16'hA5A5, 4'd5,  4'd5,  4'd5,  16'hA5A5, 16'hA5A5, 16'h0001, 1'b0};
    vecs[6]  = '{1'b0, 4'd2,  16'hFFFF, 4'd2,  4'd5,  4'd5,  16'h0000, 16'hA5A5, 16'hA5A5, 1'b0};
    vecs[7]  = '{1'b0, 4'd2,  16'hFFFF, 4'd2,  4'd2,  4'd2,  16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[8]  = '{1'b0, 4'd2,  16'hFFFF, 4'd2,  4'd2,  4'd2,  16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[9]  = '{1'b1, 4'd0,  16'hCAFE, 4'd0,  4'd15, 4'd0,  16'hCAFE, 16'h0000, 16'h0000, 1'b0};
    vecs[10] = '{1'b1, 4'd13, 16'h5555, 4'd13, 4'd0,  4'd13, 16'h0000, 16'hCAFE, 16'h0000, 1'b1};
    vecs[11] = '{1'b0, 4'bx,  16'h1111, 4'd10, 4'd0,  4'd13, 16'h0000, 16'hCAFE, 16'h0000, 1'b1};
    vecs[12] = '{1'b1, 4'd10, 16'h8001, 4'd10, 4'd12, 4'd10, 16'h8001, 16'h0000, 16'h0000, 1'b1};
    vecs[13] = '{1'b0, 4'd0,  16'h0000, 4'd10, 4'd11, 4'd9,  16'h8001, 16'h00FF, 16'hBEEF, 1'b1};

    rst      = 1'b1;
    wb_en    = 1'b0;
    wb_addr  = 4'd0;
    wb_data  = 16'h0000;
    rx_addr  = 4'd0;
    ry_addr  = 4'd1;
    dbg_addr = 4'd0;
    #2;
    checkOutput("reset_rx", rx_data, 16'h0000);
    checkOutput("reset_ry", ry_data, 16'h0000);
    checkOutput("reset_dbg", dbg_data, 16'h0000);
    checkOutput("reset_err", {15'd0, wb_err}, 16'h0000);

    @(negedge clk);
    rst = 1'b0;

    // Every architectural register reads zero after reset.
    for (int a = 0; a < 12; a++) begin
      rx_addr  = 4'(a);
      ry_addr  = 4'(11 - a);
      dbg_addr = 4'(a);
      #1;
      checkOutput($sformatf("postreset_rx_%0d", a), rx_data, 16'h0000);
      checkOutput($sformatf("postreset_ry_%0d", 11 - a), ry_data, 16'h0000);
      @(posedge clk);
      #1;
      checkOutput($sformatf("postreset_dbg_%0d", a), dbg_data, 16'h0000);
      @(negedge clk);
    end

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d_rx", i), rx_data, vecs[i].exp_rx);
      checkOutput($sformatf("vec%0d_ry", i), ry_data, vecs[i].exp_ry);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_dbg", i), dbg_data, vecs[i].exp_dbg);
      checkOutput($sformatf("vec%0d_err", i), {15'd0, wb_err}, {15'd0, vecs[i].exp_err});
      @(negedge clk);
    end

    // Asynchronous reset between edges clears state and suppresses bypass.
    wb_en    = 1'b1;
    wb_addr  = 4'd3;
    wb_data  = 16'h9999;
    rx_addr  = 4'd3;
    ry_addr  = 4'd9;
    dbg_addr = 4'd9;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_rx_nobypass", rx_data, 16'h0000);
    checkOutput("async_rst_ry", ry_data, 16'h0000);
    checkOutput("async_rst_dbg", dbg_data, 16'h0000);
    checkOutput("async_rst_err", {15'd0, wb_err}, 16'h0000);

    // A write held across an edge while in reset must not commit.
    wb_addr = 4'd8;
    wb_data = 16'h7777;
    rx_addr = 4'd8;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    wb_en = 1'b0;
    #1;
    checkOutput("rst_mid_write_T", rx_data, 16'h0000);
    @(negedge clk);
    wb_en = 1'b1;
    @(posedge clk);
    #1;
    wb_en = 1'b0;
    #1;
    checkOutput("write_after_rst_T", rx_data, 16'h7777);
    checkOutput("write_after_rst_err", {15'd0, wb_err}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Register file that terminates the write-back address path: consumes the selected write-back destination (address, data, enable) and commits it to architectural state.
- Serves two combinational operand read ports to decode/ID plus one debug read port.
- Provides same-cycle write-to-read bypass, so the pipeline needs no extra forwarding stage for the WB to ID distance.
- Holds general registers R0-R7 and special registers T, SP, IH, RA.

Parameters:
- DATA_W, 16, register data width
- ADDR_W, 4, register address width; bit 3 clear selects R0-R7, bit 3 set selects special registers
- NUM_GPR, 8, number of general registers (fixed by the ISA; not meant to change)

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-high reset
- wb_en  input  1  write-back enable; 0 when write-back op is NOP
- wb_addr  input  ADDR_W  write-back destination address
- wb_data  input  DATA_W  write-back data
- rx_addr  input  ADDR_W  read port X address
- ry_addr  input  ADDR_W  read port Y address
- rx_data  output  DATA_W  read port X data
- ry_data  output  DATA_W  read port Y data
- dbg_addr  input  ADDR_W  debug read address
- dbg_data  output  DATA_W  debug read data; registered, one-cycle latency
- wb_err  output  1  registered sticky flag: set when a write targets a reserved address

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high (rst); on assertion all state clears immediately, regardless of clk.
- Address map:
  - 0-7 = R0-R7
  - 8 = T
  - 9 = SP
  - 10 = IH
  - 11 = RA
  - 12-15 = reserved
- Reset values:
  - all 12 registers = 0; dbg_data = 0; wb_err = 0.
  - rx_data and ry_data therefore read 0 during reset (combinational from cleared state; bypass disabled while rst is high).
- Write:
  - on a rising clk with wb_en=1 and rst=0, the addressed register takes wb_data.
  - wb_en=0 leaves all state unchanged, whatever wb_addr and wb_data hold.
  - X or Z on wb_addr while wb_en=0 must not corrupt state.
- Reserved write (wb_en=1, wb_addr 12-15): no register changes; wb_err is set on that edge and stays 1 until reset.
- Read ports X and Y:
  - combinational, zero-latency.
  - if wb_en=1 and wb_addr equals the read address (valid address only), the output returns wb_data in the same cycle (bypass).
  - otherwise the output returns the stored value.
  - reserved read addresses return 0, with no bypass.
- Both read ports may address the same register, and both may match the write address at once; each bypasses independently.
- Debug port:
  - on each rising clk, dbg_data <= the stored value at dbg_addr, with no bypass. It shows the pre-write value when a write to the same address lands on the same edge.
  - reserved addresses load 0.
- No R0-hardwired-zero behaviour: R0 is an ordinary writable register.
- Reset mid-operation: an asserted rst overrides any concurrent write; the first write after deassertion commits on the first rising clk with rst=0.
- Data is stored verbatim: no sign extension, truncation or width conversion.

Test Plan:
1. Reset: assert rst=1 asynchronously between edges -> rx_data=ry_data=dbg_data=0 and wb_err=0 immediately; after release, reading all addresses 0-11 returns 0x0000.
2. Write/readback: write R3=0x1234, SP=0xBEEF, RA=0x00FF on consecutive cycles with wb_en=1 -> next cycle rx_addr=3 gives 0x1234, ry_addr=9 gives 0xBEEF; dbg_addr=11 gives 0x00FF one cycle after being set.
3. Bypass: with R5=0x0001 stored, drive wb_en=1, wb_addr=5, wb_data=0xA5A5 and rx_addr=ry_addr=5 in the same cycle -> both outputs show 0xA5A5 before the edge. dbg_addr=5 on that edge latches 0x0001; on the following edge it latches 0xA5A5.
4. Write disabled: wb_en=0, wb_addr=2, wb_data=0xFFFF for 3 cycles -> R2 keeps its prior value 0x0000, and rx_addr=2 shows 0x0000 (no bypass).
5. Reserved address: wb_en=1, wb_addr=13, wb_data=0x5555 -> no register changes, wb_err=1 after the edge and stays 1; rx_addr=13 reads 0x0000.
6. Reset mid-write: wb_en=1, wb_addr=8, wb_data=0x7777 with rst pulsed high across the edge -> T=0x0000 after rst drops. The same write held for one more edge with rst=0 -> T=0x7777.
